// File: rtl/dit_bfly_pkg.sv
// Shared helpers for the radix-2 DIT butterfly: pipeline latency, unity-coefficient
// scaling, and convergent rounding / saturation on a 64-bit working width.
package dit_bfly_pkg;

    localparam int WORK_W = 64;

    typedef logic signed [WORK_W-1:0] work_t;

    function automatic int lat(input int mpy_stages);
        return mpy_stages + 32'sd5;
    endfunction

    function automatic int cunity_shift(input int cwidth);
        return cwidth - 32'sd2;
    endfunction

    // Round half to even while discarding `drop` fraction bits.
    function automatic work_t conv_round(input work_t val, input int drop);
        work_t trunc_v;
        work_t frac_v;
        work_t half_v;
        work_t mask_v;
        work_t res_v;
        if (drop <= 32'sd0) begin
            res_v = val;
        end else begin
            mask_v  = (64'sd1 <<< drop) - 64'sd1;
            half_v  = 64'sd1 <<< (drop - 32'sd1);
            trunc_v = val >>> drop;
            frac_v  = val & mask_v;
            if ((frac_v > half_v) || ((frac_v == half_v) && trunc_v[0])) begin
                res_v = trunc_v + 64'sd1;
            end else begin
                res_v = trunc_v;
            end
        end
        return res_v;
    endfunction

    function automatic work_t sat_clamp(input work_t val, input int owidth);
        work_t max_v;
        work_t min_v;
        work_t res_v;
        max_v = (64'sd1 <<< (owidth - 32'sd1)) - 64'sd1;
        min_v = -(64'sd1 <<< (owidth - 32'sd1));
        if (val > max_v) begin
            res_v = max_v;
        end else if (val < min_v) begin
            res_v = min_v;
        end else begin
            res_v = val;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/dit_butterfly_cmpy.sv
// Pipelined three-multiplier (Karatsuba) complex product R*C for the DIT butterfly,
// with a matching register chain that carries L so both arrive together.
module dit_cmpy3
    import dit_bfly_pkg::*;
#(
    parameter int IWIDTH     = 16,
    parameter int CWIDTH     = 20,
    parameter int MPY_STAGES = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            ce_i,
    input  logic        [2*IWIDTH-1:0]      left_i,
    input  logic        [2*IWIDTH-1:0]      right_i,
    input  logic        [2*CWIDTH-1:0]      coef_i,
    output logic signed [IWIDTH+CWIDTH+1:0] m_r_o,
    output logic signed [IWIDTH+CWIDTH+1:0] m_i_o,
    output logic        [2*IWIDTH-1:0]      left_o
);

    localparam int PW    = IWIDTH + CWIDTH + 2;
    localparam int DEPTH = MPY_STAGES + 2;

    logic signed [IWIDTH-1:0] r_r_s;
    logic signed [IWIDTH-1:0] r_i_s;
    logic signed [CWIDTH-1:0] c_r_s;
    logic signed [CWIDTH-1:0] c_i_s;
    logic signed [IWIDTH:0]   p3a_d;
    logic signed [CWIDTH:0]   p3b_d;

    logic signed [IWIDTH:0]   r_r_q;
    logic signed [IWIDTH:0]   r_i_q;
    logic signed [IWIDTH:0]   p3a_q;
    logic signed [CWIDTH:0]   c_r_q;
    logic signed [CWIDTH:0]   c_i_q;
    logic signed [CWIDTH:0]   p3b_q;

    logic signed [PW-1:0]     p1_d;
    logic signed [PW-1:0]     p2_d;
    logic signed [PW-1:0]     p3_d;
    logic signed [PW-1:0]     p1_q [MPY_STAGES];
    logic signed [PW-1:0]     p2_q [MPY_STAGES];
    logic signed [PW-1:0]     p3_q [MPY_STAGES];

    logic        [2*IWIDTH-1:0] l_q [DEPTH];

    // Split operands, form the Karatsuba pre-sums and the three raw products.
    always_comb begin
        r_r_s = $signed(right_i[2*IWIDTH-1:IWIDTH]);
        r_i_s = $signed(right_i[IWIDTH-1:0]);
        c_r_s = $signed(coef_i[2*CWIDTH-1:CWIDTH]);
        c_i_s = $signed(coef_i[CWIDTH-1:0]);
        p3a_d = (IWIDTH+1)'(r_r_s) + (IWIDTH+1)'(r_i_s);
        p3b_d = (CWIDTH+1)'(c_r_s) + (CWIDTH+1)'(c_i_s);
        p1_d  = PW'(r_r_q) * PW'(c_r_q);
        p2_d  = PW'(r_i_q) * PW'(c_i_q);
        p3_d  = PW'(p3a_q) * PW'(p3b_q);
    end

    // Pre-add, multiply pipeline, combine stage and the L delay line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_r_q <= '0;
            r_i_q <= '0;
            p3a_q <= '0;
            c_r_q <= '0;
            c_i_q <= '0;
            p3b_q <= '0;
            for (int k = 0; k < MPY_STAGES; k++) begin
                p1_q[k] <= '0;
                p2_q[k] <= '0;
                p3_q[k] <= '0;
            end
            for (int k = 0; k < DEPTH; k++) begin
                l_q[k] <= '0;
            end
            m_r_o <= '0;
            m_i_o <= '0;
        end else if (ce_i) begin
            r_r_q   <= (IWIDTH+1)'(r_r_s);
            r_i_q   <= (IWIDTH+1)'(r_i_s);
            p3a_q   <= p3a_d;
            c_r_q   <= (CWIDTH+1)'(c_r_s);
            c_i_q   <= (CWIDTH+1)'(c_i_s);
            p3b_q   <= p3b_d;
            p1_q[0] <= p1_d;
            p2_q[0] <= p2_d;
            p3_q[0] <= p3_d;
            for (int k = 1; k < MPY_STAGES; k++) begin
                p1_q[k] <= p1_q[k-1];
                p2_q[k] <= p2_q[k-1];
                p3_q[k] <= p3_q[k-1];
            end
            l_q[0] <= left_i;
            for (int k = 1; k < DEPTH; k++) begin
                l_q[k] <= l_q[k-1];
            end
            // m_i = (Rr+Ri)(Cr+Ci) - RrCr - RiCi = RrCi + RiCr
            m_r_o <= p1_q[MPY_STAGES-1] - p2_q[MPY_STAGES-1];
            m_i_o <= p3_q[MPY_STAGES-1] - p1_q[MPY_STAGES-1] - p2_q[MPY_STAGES-1];
        end
    end

    assign left_o = l_q[DEPTH-1];

endmodule

// File: rtl/dit_butterfly.sv
// Radix-2 DIT butterfly: L' = L + R*C, R' = L - R*C, fixed latency MPY_STAGES+5.
// Build option DIT_BFLY_SATURATE_EN clamps out-of-range results instead of wrapping.
module dit_butterfly
    import dit_bfly_pkg::*;
#(
    parameter int IWIDTH     = 16,
    parameter int CWIDTH     = 20,
    parameter int OWIDTH     = 17,
    parameter int SHIFT      = 0,
    parameter int MPY_STAGES = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clk_enable,
    input  logic [2*CWIDTH-1:0]   i_coef,
    input  logic [2*IWIDTH-1:0]   i_left,
    input  logic [2*IWIDTH-1:0]   i_right,
    input  logic                  i_aux,
    output logic [2*OWIDTH-1:0]   o_left,
    output logic [2*OWIDTH-1:0]   o_right,
    output logic                  o_aux
);

    localparam int LATENCY      = lat(MPY_STAGES);
    localparam int CUNITY_SHIFT = cunity_shift(CWIDTH);
    localparam int PW           = IWIDTH + CWIDTH + 2;
    localparam int AW           = IWIDTH + CWIDTH + 3;
    localparam int DROP         = CUNITY_SHIFT - SHIFT;

    logic [2*IWIDTH-1:0]   left_q;
    logic [2*IWIDTH-1:0]   right_q;
    logic [2*CWIDTH-1:0]   coef_q;
    logic [LATENCY-1:0]    aux_q;

    logic signed [PW-1:0]  m_r_s;
    logic signed [PW-1:0]  m_i_s;
    logic [2*IWIDTH-1:0]   l_dly_s;

    logic signed [IWIDTH-1:0] l_r_s;
    logic signed [IWIDTH-1:0] l_i_s;
    logic signed [AW-1:0]  ls_r_s;
    logic signed [AW-1:0]  ls_i_s;
    logic signed [AW-1:0]  sum_lr_d;
    logic signed [AW-1:0]  sum_li_d;
    logic signed [AW-1:0]  sum_rr_d;
    logic signed [AW-1:0]  sum_ri_d;
    logic signed [AW-1:0]  sum_lr_q;
    logic signed [AW-1:0]  sum_li_q;
    logic signed [AW-1:0]  sum_rr_q;
    logic signed [AW-1:0]  sum_ri_q;

    function automatic logic [OWIDTH-1:0] fit_out(input logic signed [AW-1:0] v);
        work_t r;
        r = conv_round(work_t'(v), DROP);
`ifdef DIT_BFLY_SATURATE_EN
        r = sat_clamp(r, OWIDTH);
`endif
        return r[OWIDTH-1:0];
    endfunction

    dit_cmpy3 #(
        .IWIDTH     (IWIDTH),
        .CWIDTH     (CWIDTH),
        .MPY_STAGES (MPY_STAGES)
    ) u_cmpy (
        .clk_i   (i_clk),
        .rst_n_i (i_reset_n),
        .ce_i    (i_clk_enable),
        .left_i  (left_q),
        .right_i (right_q),
        .coef_i  (coef_q),
        .m_r_o   (m_r_s),
        .m_i_o   (m_i_s),
        .left_o  (l_dly_s)
    );

    // Lift L onto the product scale (unity = 2^CUNITY_SHIFT) and form both legs.
    always_comb begin
        l_r_s    = $signed(l_dly_s[2*IWIDTH-1:IWIDTH]);
        l_i_s    = $signed(l_dly_s[IWIDTH-1:0]);
        ls_r_s   = AW'(l_r_s) <<< CUNITY_SHIFT;
        ls_i_s   = AW'(l_i_s) <<< CUNITY_SHIFT;
        sum_lr_d = ls_r_s + AW'(m_r_s);
        sum_li_d = ls_i_s + AW'(m_i_s);
        sum_rr_d = ls_r_s - AW'(m_r_s);
        sum_ri_d = ls_i_s - AW'(m_i_s);
    end

    // Input latch, add stage, round stage and aux alignment chain.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            left_q   <= '0;
            right_q  <= '0;
            coef_q   <= '0;
            aux_q    <= '0;
            sum_lr_q <= '0;
            sum_li_q <= '0;
            sum_rr_q <= '0;
            sum_ri_q <= '0;
            o_left   <= '0;
            o_right  <= '0;
        end else if (i_clk_enable) begin
            left_q   <= i_left;
            right_q  <= i_right;
            coef_q   <= i_coef;
            aux_q    <= {aux_q[LATENCY-2:0], i_aux};
            sum_lr_q <= sum_lr_d;
            sum_li_q <= sum_li_d;
            sum_rr_q <= sum_rr_d;
            sum_ri_q <= sum_ri_d;
            o_left   <= {fit_out(sum_lr_q), fit_out(sum_li_q)};
            o_right  <= {fit_out(sum_rr_q), fit_out(sum_ri_q)};
        end
    end

    assign o_aux = aux_q[LATENCY-1];

endmodule

// File: tb/tb_dit_butterfly.sv
// Directed self-checking bench for dit_butterfly (default build and OWIDTH=16 overflow instance).
module tb_dit_butterfly;

    localparam int     UNITY = 262144;
`ifdef DIT_BFLY_SATURATE_EN
    localparam longint OVF_EXP = 32767;
`else
    localparam longint OVF_EXP = -2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [39:0] d_coef;
    logic [31:0] d_left;
    logic [31:0] d_right;
    logic        d_aux;
    logic [33:0] o_left;
    logic [33:0] o_right;
    logic        o_aux;
    logic [31:0] v_left;
    logic [31:0] v_right;
    logic        v_aux;

    int n_tests = 0;
    int n_fail  = 0;

    int     s_v [64][6];
    longint e_v [64][4];

    always #5 clk = ~clk;

    dit_butterfly u_dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_clk_enable (en),
        .i_coef       (d_coef),
        .i_left       (d_left),
        .i_right      (d_right),
        .i_aux        (d_aux),
        .o_left       (o_left),
        .o_right      (o_right),
        .o_aux        (o_aux)
    );

    dit_butterfly #(.OWIDTH(16)) u_ovf (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_clk_enable (en),
        .i_coef       (d_coef),
        .i_left       (d_left),
        .i_right      (d_right),
        .i_aux        (d_aux),
        .o_left       (v_left),
        .o_right      (v_right),
        .o_aux        (v_aux)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint hi17(input logic [33:0] v);
        logic signed [16:0] t;
        t = v[33:17];
        return longint'(t);
    endfunction

    function automatic longint lo17(input logic [33:0] v);
        logic signed [16:0] t;
        t = v[16:0];
        return longint'(t);
    endfunction

    function automatic longint hi16(input logic [31:0] v);
        logic signed [15:0] t;
        t = v[31:16];
        return longint'(t);
    endfunction

    // Exact value / 2^18, round half to even, wrapped to 17 bits.
    function automatic longint ref_out(input longint v);
        longint q;
        longint r;
        logic signed [16:0] t;
        q = v / UNITY;
        if ((v % UNITY) != 0 && v < 0) q = q - 1;
        r = v - q * UNITY;
        if (2 * r > UNITY || (2 * r == UNITY && (q % 2) != 0)) q = q + 1;
        t = q[16:0];
        return longint'(t);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int lr, input int li, input int rr, input int ri,
                         input int cr, input int ci, input logic aux);
        d_left  = {16'(lr), 16'(li)};
        d_right = {16'(rr), 16'(ri)};
        d_coef  = {20'(cr), 20'(ci)};
        d_aux   = aux;
    endtask

    task automatic run_vec(input string nm, input int lr, input int li, input int rr,
                           input int ri, input int cr, input int ci,
                           input longint xlr, input longint xli,
                           input longint xrr, input longint xri);
        drive(lr, li, rr, ri, cr, ci, 1'b1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (6) step();
        check_eq({nm, "_aux_early"}, longint'(o_aux), 0);
        step();
        check_eq({nm, "_left_r"},  hi17(o_left),  xlr);
        check_eq({nm, "_left_i"},  lo17(o_left),  xli);
        check_eq({nm, "_right_r"}, hi17(o_right), xrr);
        check_eq({nm, "_right_i"}, lo17(o_right), xri);
        check_eq({nm, "_aux"},     longint'(o_aux), 1);
        step();
        check_eq({nm, "_aux_late"}, longint'(o_aux), 0);
    endtask

    initial begin
        int     fed;
        int     en_edges;
        int     cyc;
        int     burst;
        int     idx;
        logic   aux_seen;
        longint mr;
        longint mi;

        rst_n = 1'b0;
        en    = 1'b1;
        drive(1000, -500, 200, 300, UNITY, 0, 1'b1);
        repeat (2) step();
        check_eq("reset_left",  longint'(o_left),  0);
        check_eq("reset_right", longint'(o_right), 0);
        check_eq("reset_aux",   longint'(o_aux),   0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (10) step();

        run_vec("unity", 1000, -500, 200, 300, UNITY, 0, 1200, -200, 800, -800);
        run_vec("negj",  1000, -500, 200, 300, 0, -UNITY, 1300, -700, 700, -300);
        run_vec("round", 0, 0, 3, 1, UNITY / 2, 0, 2, 0, -2, 0);

        // Overflow: 65534 fits 17 bits, wraps or clamps at 16 bits.
        drive(32767, 0, 32767, 0, UNITY, 0, 1'b0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (7) step();
        check_eq("ovf17_left_r",  hi17(o_left),  65534);
        check_eq("ovf17_right_r", hi17(o_right), 0);
        check_eq("ovf16_left_r",  hi16(v_left),  OVF_EXP);
        check_eq("ovf16_right_r", hi16(v_right), 0);

        for (int k = 0; k < 64; k++) begin
            s_v[k][0] = int'($urandom_range(60000)) - 30000;
            s_v[k][1] = int'($urandom_range(60000)) - 30000;
            s_v[k][2] = int'($urandom_range(60000)) - 30000;
            s_v[k][3] = int'($urandom_range(60000)) - 30000;
            s_v[k][4] = int'($urandom_range(262144)) - 131072;
            s_v[k][5] = int'($urandom_range(262144)) - 131072;
            mr = longint'(s_v[k][2]) * s_v[k][4] - longint'(s_v[k][3]) * s_v[k][5];
            mi = longint'(s_v[k][2]) * s_v[k][5] + longint'(s_v[k][3]) * s_v[k][4];
            e_v[k][0] = ref_out(longint'(s_v[k][0]) * UNITY + mr);
            e_v[k][1] = ref_out(longint'(s_v[k][1]) * UNITY + mi);
            e_v[k][2] = ref_out(longint'(s_v[k][0]) * UNITY - mr);
            e_v[k][3] = ref_out(longint'(s_v[k][1]) * UNITY - mi);
        end

        // Stall stream: garbage with aux=1 is driven whenever enable is low.
        fed = 0;
        en_edges = 0;
        cyc = 0;
        burst = 0;
        while (en_edges < 71 && cyc < 3000) begin
            if (burst > 0) begin
                en = 1'b0;
                burst--;
            end else begin
                en = 1'b1;
                if ($urandom_range(3) == 0) burst = int'($urandom_range(5, 1));
            end
            if (!en) begin
                drive(int'($urandom_range(1000)), 7, 9, 11, 1234, 5678, 1'b1);
            end else if (fed < 64) begin
                drive(s_v[fed][0], s_v[fed][1], s_v[fed][2], s_v[fed][3],
                      s_v[fed][4], s_v[fed][5], fed == 0);
                fed++;
            end else begin
                drive(0, 0, 0, 0, 0, 0, 1'b0);
            end
            step();
            cyc++;
            if (en) en_edges++;
            check_eq($sformatf("stall_aux_e%0d", en_edges), longint'(o_aux),
                     longint'(en_edges == 8));
            if (en_edges >= 8) begin
                idx = en_edges - 8;
                check_eq($sformatf("stall_lr_%0d", idx), hi17(o_left),  e_v[idx][0]);
                check_eq($sformatf("stall_li_%0d", idx), lo17(o_left),  e_v[idx][1]);
                check_eq($sformatf("stall_rr_%0d", idx), hi17(o_right), e_v[idx][2]);
                check_eq($sformatf("stall_ri_%0d", idx), lo17(o_right), e_v[idx][3]);
            end
        end
        check_eq("stall_budget", longint'(en_edges), 71);
        en = 1'b1;

        // Reset mid-stream with an aux marker in flight.
        for (int k = 0; k < 9; k++) begin
            drive(1000, -500, 200, 300, UNITY, 0, k == 5);
            step();
        end
        check_eq("pre_rst_left_r", hi17(o_left), 1200);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_left",  longint'(o_left),  0);
        check_eq("midrst_right", longint'(o_right), 0);
        check_eq("midrst_aux",   longint'(o_aux),   0);
        repeat (2) step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        aux_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            aux_seen = aux_seen | o_aux;
        end
        check_eq("postrst_aux_quiet", longint'(aux_seen), 0);
        run_vec("postrst", 1000, -500, 200, 300, UNITY, 0, 1200, -200, 800, -800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
